// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO read-port arbiter.
package io_arb_pkg;

    localparam int unsigned IO_ARB_ID_W = 2;

    localparam int unsigned REQ_IN_DATA  = 0;
    localparam int unsigned REQ_WEIGHT   = 1;
    localparam int unsigned REQ_BIAS     = 2;
    localparam int unsigned REQ_OUT_DATA = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } io_arb_state_e;

    typedef struct packed {
        logic                   valid;
        logic [IO_ARB_ID_W-1:0] id;
        logic                   last;
    } io_tag_t;

endpackage

// File: rtl/io_port_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search starts one past the pointer and wraps.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int unsigned j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            j = (32'(i_ptr) + off) % N;
            if (!o_any && i_req[IW'(j)]) begin
                o_any          = 1'b1;
                o_idx          = IW'(j);
                o_gnt[IW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares the IO memory read port between burst requesters and routes returned words back.
// Optional IO_ARB_STRICT_PRIO_EN: requester 0 preempts the round-robin among the others.
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned IO_DATA_WIDTH  = 32,
    parameter int unsigned IO_ADDR_WIDTH  = 16,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned MEM_RD_LATENCY = 2,
    localparam int unsigned BW            = $clog2(MAX_BURST + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*IO_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BW-1:0]            req_len,
    output logic                             mem_req_valid,
    output logic [IO_ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic [IO_DATA_WIDTH-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [IO_DATA_WIDTH-1:0]         rsp_data,
    output logic                             rsp_last,
    output logic                             busy
);

    io_arb_state_e          r_state;
    logic [IO_ARB_ID_W-1:0] r_ptr;
    logic [IO_ARB_ID_W-1:0] r_id;
    logic [IO_ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]          r_rem;
    io_tag_t                r_tag [MEM_RD_LATENCY];

    logic [NUM_REQ-1:0]       w_arb_req;
    logic [NUM_REQ-1:0]       w_gnt;
    logic [IO_ARB_ID_W-1:0]   w_gnt_idx;
    logic                     w_gnt_any;
    logic                     w_hs;
    logic [IO_ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic [BW-1:0]            w_len_arr  [NUM_REQ];
    logic [IO_ADDR_WIDTH-1:0] w_addr_sel;
    logic [BW-1:0]            w_len_sel;
    logic [BW-1:0]            w_len_clamped;
    io_tag_t                  w_tag_in;
    io_tag_t                  w_out;
    logic                     w_tag_any;

`ifdef IO_ARB_STRICT_PRIO_EN
    assign w_arb_req = req_valid[REQ_IN_DATA] ? (NUM_REQ'(1) << REQ_IN_DATA) : req_valid;
`else
    assign w_arb_req = req_valid;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IO_ARB_ID_W)
    ) u_rr (
        .i_req (w_arb_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_addr_arr[i] = req_addr[i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
            w_len_arr[i]  = req_len[i*BW +: BW];
        end
    end

    assign w_addr_sel    = w_addr_arr[w_gnt_idx];
    assign w_len_sel     = w_len_arr[w_gnt_idx];
    assign w_len_clamped = (w_len_sel > BW'(MAX_BURST)) ? BW'(MAX_BURST) : w_len_sel;

    assign w_hs      = (r_state == IDLE) && w_gnt_any;
    assign req_ready = (rstn && r_state == IDLE) ? w_gnt : '0;

    // Tag entering the latency pipeline for the beat issued this cycle
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = (r_state == ISSUE);
        w_tag_in.id    = r_id;
        w_tag_in.last  = (r_state == ISSUE) && (r_rem == BW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= IO_ARB_ID_W'(NUM_REQ - 1);
            r_id    <= '0;
            r_addr  <= '0;
            r_rem   <= '0;
            for (int unsigned i = 0; i < MEM_RD_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int unsigned i = 1; i < MEM_RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_ptr  <= w_gnt_idx;
                        r_id   <= w_gnt_idx;
                        r_addr <= w_addr_sel;
                        r_rem  <= w_len_clamped;
                        if (w_len_clamped != '0) begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_addr <= r_addr + IO_ADDR_WIDTH'(1);
                    r_rem  <= r_rem - BW'(1);
                    if (r_rem == BW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = (r_state == ISSUE);
    assign mem_req_addr  = r_addr;

    always_comb begin
        w_tag_any = 1'b0;
        for (int unsigned i = 0; i < MEM_RD_LATENCY; i++) begin
            w_tag_any = w_tag_any | r_tag[i].valid;
        end
    end

    assign busy = (r_state == ISSUE) || w_tag_any;

    // Pipeline head lines up with the word memory returns this cycle
    assign w_out     = r_tag[MEM_RD_LATENCY-1];
    assign rsp_valid = w_out.valid ? (NUM_REQ'(1) << w_out.id) : '0;
    assign rsp_data  = w_out.valid ? mem_rdata : '0;
    assign rsp_last  = w_out.valid && w_out.last;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: directed table/sequences plus random traffic against a beat-queue model.
module tb_io_port_arbiter;

    localparam int L = 2;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_addr;
    logic [19:0] req_len;
    logic        mem_req_valid;
    logic [15:0] mem_req_addr;
    logic [31:0] mem_rdata;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;

    io_port_arbiter #(
        .IO_DATA_WIDTH  (32),
        .IO_ADDR_WIDTH  (16),
        .NUM_REQ        (4),
        .MAX_BURST      (16),
        .MEM_RD_LATENCY (L)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Memory: returns memf(addr) L cycles after the address was presented
    logic [15:0] m_d [L];
    always @(posedge clk) begin
        m_d[0] <= mem_req_addr;
        for (int i = 1; i < L; i++) m_d[i] <= m_d[i-1];
    end
    assign mem_rdata = memf(m_d[L-1]);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats waiting to issue, and responses due at a given cycle
    typedef struct { int id; logic [15:0] addr; logic last; } beat_t;
    typedef struct { int due; int id; logic [15:0] addr; logic last; } rsp_t;
    beat_t beatq[$];
    rsp_t  rspq[$];
    int    m_ptr = 3;
    int    cyc   = 0;

    function automatic int pick(input logic [3:0] rv, input int ptr);
        int j;
`ifdef IO_ARB_STRICT_PRIO_EN
        if (rv[0]) return 0;
`endif
        for (int k = 1; k <= 4; k++) begin
            j = (ptr + k) % 4;
            if (rv[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic model();
        int win;
        int n;
        logic [3:0] er;
        logic eb;
        beat_t b;
        win = -1;
        if (rstn && beatq.size() == 0) win = pick(req_valid, m_ptr);
        er = (win >= 0) ? (4'(1) << win) : 4'd0;
        chk("m_ready", 32'(req_ready), 32'(er));
        if (!rstn) begin
            beatq.delete();
            rspq.delete();
            m_ptr = 3;
        end else begin
            eb = (beatq.size() != 0) || (rspq.size() != 0);
            chk("m_busy", 32'(busy), 32'(eb));
            chk("m_mem_valid", 32'(mem_req_valid), 32'(beatq.size() != 0));
            if (beatq.size() != 0) chk("m_mem_addr", 32'(mem_req_addr), 32'(beatq[0].addr));
            if (rspq.size() != 0 && rspq[0].due == cyc) begin
                chk("m_rsp_valid", 32'(rsp_valid), 32'(4'(1) << rspq[0].id));
                chk("m_rsp_last", 32'(rsp_last), 32'(rspq[0].last));
                chk("m_rsp_data", rsp_data, memf(rspq[0].addr));
                void'(rspq.pop_front());
            end else begin
                chk("m_rsp_idle", {27'd0, rsp_valid, rsp_last}, 32'd0);
            end
            if (beatq.size() != 0) begin
                b = beatq.pop_front();
                rspq.push_back('{due: cyc + L, id: b.id, addr: b.addr, last: b.last});
            end
            if (win >= 0) begin
                m_ptr = win;
                n = int'(req_len[win*5 +: 5]);
                if (n > 16) n = 16;
                for (int k = 0; k < n; k++)
                    beatq.push_back('{id: win, addr: 16'(req_addr[win*16 +: 16] + 16'(k)), last: (k == n - 1)});
            end
        end
        cyc++;
    endtask

    logic [3:0]  s_ready, s_rsp;
    logic        s_mv, s_last, s_busy;
    logic [15:0] s_maddr;
    logic [31:0] s_data;

    task automatic cycle();
        #1;
        s_ready = req_ready; s_rsp = rsp_valid; s_mv = mem_req_valid; s_last = rsp_last;
        s_busy = busy; s_maddr = mem_req_addr; s_data = rsp_data;
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [4:0] l);
        req_valid[i]       = v;
        req_addr[i*16 +: 16] = a;
        req_len[i*5 +: 5]  = l;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  ready;
        logic        mv;
        logic [15:0] maddr;
        logic [3:0]  rsp;
        logic        last;
        logic        busy;
    } vec_t;

    vec_t tbl [8];
    int   exp_order [5];
    int   exp_prio  [3];
    logic [15:0] wrap_addr [4];
    int   nbeats;

    initial begin
        rstn = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
        tbl[0] = '{4'b0010, 4'b0010, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{4'b0000, 4'b0000, 1'b1, 16'h0100, 4'b0000, 1'b0, 1'b1};
        tbl[2] = '{4'b0000, 4'b0000, 1'b1, 16'h0101, 4'b0000, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 4'b0000, 1'b1, 16'h0102, 4'b0010, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 1'b1, 16'h0103, 4'b0010, 1'b0, 1'b1};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0010, 1'b0, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0010, 1'b1, 1'b1};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
`ifdef IO_ARB_STRICT_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
        exp_prio  = '{0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
        exp_prio  = '{0, 2, 0};
`endif
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        @(posedge clk);
        #1;

        // Reset values
        do_reset();
        cycle();
        chk("rst_outputs", {s_ready, s_rsp, s_mv, s_last, s_busy}, 32'd0);
        chk("rst_mem_addr", 32'(s_maddr), 32'd0);
        chk("rst_rsp_data", s_data, 32'd0);

        // Single request, table-driven
        set_req(1, 1'b0, 16'h0100, 5'd4);
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].rv;
            cycle();
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_mv", i), 32'(s_mv), 32'(tbl[i].mv));
            if (tbl[i].mv) chk($sformatf("tbl%0d_maddr", i), 32'(s_maddr), 32'(tbl[i].maddr));
            chk($sformatf("tbl%0d_rsp", i), 32'(s_rsp), 32'(tbl[i].rsp));
            chk($sformatf("tbl%0d_last", i), 32'(s_last), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
        end

        // Round-robin fairness with all four requesting len 1
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(i * 16'h1000), 5'd1);
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk($sformatf("rr_c%0d", c), 32'(s_ready), (c % 2 == 0) ? 32'(4'(1) << exp_order[c/2]) : 32'd0);
        end

        // Requester 0 versus 2, then 0 drops out
        do_reset();
        set_req(0, 1'b1, 16'h0010, 5'd1);
        set_req(2, 1'b1, 16'h0020, 5'd1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c % 2 == 0) chk($sformatf("prio_c%0d", c), 32'(s_ready), 32'(4'(1) << exp_prio[c/2]));
        end
        set_req(0, 1'b0, 16'h0010, 5'd1);
        cycle();
        chk("prio_drop0", 32'(s_ready), 32'(4'b0100));
        req_valid = '0;
        for (int c = 0; c < 4; c++) cycle();

        // Address wrap
        do_reset();
        set_req(3, 1'b1, 16'hFFFE, 5'd4);
        cycle();
        chk("wrap_hs", 32'(s_ready), 32'(4'b1000));
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("wrap_b%0d", k), {15'd0, s_mv, s_maddr}, {15'd0, 1'b1, wrap_addr[k]});
        end
        cycle();
        chk("wrap_end", 32'(s_mv), 32'd0);
        for (int c = 0; c < 3; c++) cycle();

        // Zero length: handshake only
        do_reset();
        set_req(2, 1'b1, 16'h0200, 5'd0);
        cycle();
        chk("len0_hs", 32'(s_ready), 32'(4'b0100));
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk($sformatf("len0_quiet%0d", c), {27'd0, s_mv, s_rsp}, 32'd0);
        end

        // Oversized length clamps to 16 beats
        set_req(1, 1'b1, 16'h0300, 5'd20);
        cycle();
        chk("clamp_hs", 32'(s_ready), 32'(4'b0010));
        req_valid = '0;
        nbeats = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (s_mv) nbeats++;
        end
        chk("clamp_beats", 32'(nbeats), 32'd16);

        // Reset during the third beat of a len-8 burst
        do_reset();
        set_req(2, 1'b1, 16'h0400, 5'd8);
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk($sformatf("midrst_quiet%0d", c), {27'd0, s_rsp, s_busy}, 32'd0);
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'h0500, 5'd1);
        cycle();
        chk("midrst_grant", 32'(s_ready), 32'(4'b0001));
        req_valid = '0;
        for (int c = 0; c < 4; c++) cycle();

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 4; i++) begin
                set_req(i, ($urandom_range(0, 2) != 0), 16'($urandom),
                        ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 6)));
            end
            cycle();
        end
        rstn = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 30; c++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
